// File: rtl/uart_song_loader.sv
// rtl/uart_song_loader.sv - 8N1 UART receiver that packs byte pairs into 12-bit note words for the regfile.
module uart_song_loader #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int ADDR_W       = 16,
  parameter int DEPTH        = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              UART_RX,
  input  logic              writing,
  output logic [ADDR_W-1:0] addr_c,
  output logic [11:0]       data_c,
  output logic              wen_c,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_cnt,
  output logic              frame_err,
  output logic              overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W-1:0] DEPTH_W  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_W    = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;

  rx_state_e        state_q, state_d;
  logic             rx_s1_q, rx_s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic             stop_err_q, stop_err_d;

  logic              writing_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wen_q, wen_d;
  logic              phase_q, phase_d;
  logic [3:0]        hi_nib_q, hi_nib_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       data_q, data_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;

  logic rx_s;
  logic half_hit;
  logic full_hit;
  logic load_rise;
  logic load_fall;

  assign rx_s      = rx_s2_q;
  assign half_hit  = (cnt_q == HALF_M1);
  assign full_hit  = (cnt_q == FULL_M1);
  assign load_rise = writing & ~writing_q;
  assign load_fall = ~writing & writing_q;

  // Line synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= UART_RX;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (half_hit) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (full_hit && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (full_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    stop_err_d   = 1'b0;
    case (state_q)
      S_IDLE: cnt_d = '0;
      S_START: begin
        if (half_hit) begin
          cnt_d = '0;
          bit_d = 3'd0;
        end
      end
      S_DATA: begin
        if (full_hit) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
        end
      end
      S_STOP: begin
        if (full_hit) begin
          cnt_d        = '0;
          byte_valid_d = rx_s;
          stop_err_d   = ~rx_s;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shreg_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      stop_err_q   <= stop_err_d;
    end
  end

  // Load initialisation outranks a coincident byte; bytes outside an open load are dropped.
  always_comb begin
    busy_d      = busy_q;
    done_d      = done_q;
    wen_d       = 1'b0;
    phase_d     = phase_q;
    hi_nib_d    = hi_nib_q;
    addr_d      = addr_q;
    data_d      = data_q;
    word_cnt_d  = word_cnt_q;
    frame_err_d = frame_err_q;
    overflow_d  = overflow_q;
    if (load_rise) begin
      busy_d      = 1'b1;
      done_d      = 1'b0;
      word_cnt_d  = '0;
      addr_d      = '0;
      phase_d     = 1'b0;
      frame_err_d = 1'b0;
      overflow_d  = 1'b0;
    end else if (load_fall) begin
      busy_d  = 1'b0;
      phase_d = 1'b0;
    end else if (busy_q && stop_err_q) begin
      frame_err_d = 1'b1;
      phase_d     = 1'b0;
    end else if (busy_q && byte_valid_q) begin
      if (!phase_q) begin
        if (shreg_q == 8'hFF) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          hi_nib_d = shreg_q[3:0];
          phase_d  = 1'b1;
        end
      end else begin
        phase_d = 1'b0;
        if (word_cnt_q == DEPTH_W) begin
          overflow_d = 1'b1;
        end else begin
          data_d     = {hi_nib_q, shreg_q};
          addr_d     = word_cnt_q;
          wen_d      = 1'b1;
          word_cnt_d = word_cnt_q + ONE_W;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writing_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wen_q       <= 1'b0;
      phase_q     <= 1'b0;
      hi_nib_q    <= 4'd0;
      addr_q      <= '0;
      data_q      <= 12'd0;
      word_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      writing_q   <= writing;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wen_q       <= wen_d;
      phase_q     <= phase_d;
      hi_nib_q    <= hi_nib_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      word_cnt_q  <= word_cnt_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign addr_c    = addr_q;
  assign data_c    = data_q;
  assign wen_c     = wen_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign word_cnt  = word_cnt_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_song_loader.sv
// tb/tb_uart_song_loader.sv - self-checking bench for uart_song_loader against a byte-level song model.
module tb_uart_song_loader;
  localparam int CPB   = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          UART_RX = 1'b1;
  logic          writing = 1'b0;
  logic [AW-1:0] addr_c;
  logic [11:0]   data_c;
  logic          wen_c;
  logic          busy;
  logic          done;
  logic [AW-1:0] word_cnt;
  logic          frame_err;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  uart_song_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .UART_RX(UART_RX), .writing(writing),
    .addr_c(addr_c), .data_c(data_c), .wen_c(wen_c), .busy(busy), .done(done),
    .word_cnt(word_cnt), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Observed writes and back-to-back strobe detection.
  logic [27:0] got_q[$];
  logic [27:0] exp_q[$];
  logic        prev_wen = 1'b0;
  logic        dbl_wen  = 1'b0;
  always @(negedge clk) begin
    if (wen_c) got_q.push_back({addr_c, data_c});
    if (wen_c && prev_wen) dbl_wen = 1'b1;
    prev_wen = wen_c;
  end

  // Song model: what a load should contain, given the bytes that arrived intact.
  logic       m_busy, m_done, m_ferr, m_ovf, m_phase;
  logic [3:0] m_hi;
  int         m_cnt;

  task automatic model_clear();
    m_busy = 0; m_done = 0; m_ferr = 0; m_ovf = 0; m_phase = 0; m_hi = 0; m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_busy) return;
    if (!m_phase) begin
      if (b == 8'hFF) begin m_busy = 0; m_done = 1; end
      else begin m_hi = b[3:0]; m_phase = 1; end
    end else begin
      m_phase = 0;
      if (m_cnt >= DEPTH) m_ovf = 1;
      else begin
        exp_q.push_back({AW'(m_cnt), m_hi, b});
        m_cnt++;
      end
    end
  endtask

  function automatic logic [19:0] dut_status();
    return {busy, done, frame_err, overflow, word_cnt};
  endfunction

  function automatic logic [19:0] model_status();
    return {m_busy, m_done, m_ferr, m_ovf, AW'(m_cnt)};
  endfunction

  // -1 when observed writes equal expected writes, -2 on count difference, else first bad index.
  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic tx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_RX = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    UART_RX = 1'b1;
    repeat (stop_bit ? 4 : 24) @(posedge clk);
    #1;
    if (stop_bit) model_byte(b);
    else if (m_busy) begin m_ferr = 1; m_phase = 0; end
  endtask

  task automatic set_writing(input logic v);
    @(posedge clk); #1;
    writing = v;
    if (v) begin
      m_busy = 1; m_done = 0; m_cnt = 0; m_phase = 0; m_ferr = 0; m_ovf = 0;
    end else begin
      m_busy = 0; m_phase = 0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic start_check();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({addr_c, data_c, wen_c, busy, done, word_cnt, frame_err, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%h data=%h wen=%b busy=%b done=%b cnt=%0d ferr=%b ovf=%b, want all 0",
               addr_c, data_c, wen_c, busy, done, word_cnt, frame_err, overflow);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut_status() !== model_status()) begin
      bad++;
      $display("FAIL reset_release_status: got %h want %h", dut_status(), model_status());
    end
  endtask

  task automatic test_basic_write();
    start_check();
    set_writing(1'b1);
    tx(8'h03, 1'b1);
    tx(8'h5A, 1'b1);
    total++;
    if (got_q.size() != 1 || got_q[0] !== {16'd0, 12'h35A}) begin
      bad++;
      $display("FAIL basic_write: got %0d writes first=%h want 1 write %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 28'h0, {16'd0, 12'h35A});
    end
    total++;
    if (dut_status() !== model_status()) begin
      bad++;
      $display("FAIL basic_status: got %h want %h", dut_status(), model_status());
    end
  endtask

  task automatic test_end_marker();
    start_check();
    tx(8'hF1, 1'b1);
    tx(8'h22, 1'b1);
    tx(8'hFF, 1'b1);
    tx(8'h10, 1'b1);
    tx(8'h44, 1'b1);
    total++;
    if (first_diff() != -1 || exp_q.size() != 1 || exp_q[0] !== {16'd1, 12'h122}) begin
      bad++;
      $display("FAIL end_marker_writes: got %0d writes diff=%0d want 1 write %h", got_q.size(),
               first_diff(), {16'd1, 12'h122});
    end
    total++;
    if (dut_status() !== model_status() || !done || busy || word_cnt !== 16'd2) begin
      bad++;
      $display("FAIL end_marker_status: got %h want %h", dut_status(), model_status());
    end
  endtask

  task automatic test_frame_err();
    start_check();
    set_writing(1'b0);
    set_writing(1'b1);
    tx(8'h01, 1'b0);
    tx(8'h02, 1'b1);
    tx(8'h34, 1'b1);
    total++;
    if (first_diff() != -1 || got_q.size() != 1 || got_q[0] !== {16'd0, 12'h234}) begin
      bad++;
      $display("FAIL frame_err_writes: got %0d writes diff=%0d want 1 write %h", got_q.size(),
               first_diff(), {16'd0, 12'h234});
    end
    total++;
    if (dut_status() !== model_status() || frame_err !== 1'b1) begin
      bad++;
      $display("FAIL frame_err_status: got %h want %h", dut_status(), model_status());
    end
  endtask

  task automatic test_overflow();
    start_check();
    set_writing(1'b0);
    set_writing(1'b1);
    for (int w = 0; w < 5; w++) begin
      tx(8'($urandom_range(8'hFE, 0)), 1'b1);
      tx(8'($urandom_range(255, 0)), 1'b1);
    end
    total++;
    if (first_diff() != -1 || got_q.size() != DEPTH) begin
      bad++;
      $display("FAIL overflow_writes: got %0d writes diff=%0d want %0d", got_q.size(), first_diff(), DEPTH);
    end
    total++;
    if (dut_status() !== model_status() || overflow !== 1'b1 || word_cnt !== AW'(DEPTH)) begin
      bad++;
      $display("FAIL overflow_status: got %h want %h", dut_status(), model_status());
    end
    total++;
    if (dbl_wen !== 1'b0) begin
      bad++;
      $display("FAIL wen_single_cycle: got back-to-back=%b want 0", dbl_wen);
    end
  endtask

  task automatic test_glitch_stale();
    start_check();
    set_writing(1'b0);
    set_writing(1'b1);
    UART_RX = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    UART_RX = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    tx(8'h07, 1'b1);
    set_writing(1'b0);
    set_writing(1'b1);
    tx(8'h00, 1'b1);
    tx(8'h99, 1'b1);
    total++;
    if (first_diff() != -1 || got_q.size() != 1 || got_q[0] !== {16'd0, 12'h099}) begin
      bad++;
      $display("FAIL glitch_stale_writes: got %0d writes diff=%0d want 1 write %h", got_q.size(),
               first_diff(), {16'd0, 12'h099});
    end
    total++;
    if (dut_status() !== model_status() || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL glitch_stale_status: got %h want %h", dut_status(), model_status());
    end
  endtask

  task automatic test_random_loads();
    int n;
    for (int l = 0; l < 4; l++) begin
      start_check();
      set_writing(1'b0);
      set_writing(1'b1);
      n = $urandom_range(9, 1);
      for (int k = 0; k < n; k++) tx(8'($urandom_range(255, 0)), ($urandom_range(7, 0) != 0));
      if ($urandom_range(1, 0) == 1) begin
        if (m_phase) tx(8'($urandom_range(255, 0)), 1'b1);
        tx(8'hFF, 1'b1);
      end
      total++;
      if (first_diff() != -1) begin
        bad++;
        $display("FAIL random_load%0d_writes: got %0d writes want %0d diff=%0d", l, got_q.size(),
                 exp_q.size(), first_diff());
      end
      total++;
      if (dut_status() !== model_status()) begin
        bad++;
        $display("FAIL random_load%0d_status: got %h want %h", l, dut_status(), model_status());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    start_check();
    UART_RX = 1'b0;
    repeat (CPB + CPB / 2) @(posedge clk);
    #1;
    UART_RX = 1'b1;
    repeat (CPB) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    writing = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({addr_c, data_c, wen_c, busy, done, word_cnt, frame_err, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_mid_frame_outputs: got addr=%h data=%h cnt=%0d busy=%b done=%b, want all 0",
               addr_c, data_c, word_cnt, busy, done);
    end
    rst_n = 1'b1;
    set_writing(1'b1);
    tx(8'h0A, 1'b1);
    tx(8'hBC, 1'b1);
    total++;
    if (first_diff() != -1 || got_q.size() != 1 || got_q[0] !== {16'd0, 12'hABC}) begin
      bad++;
      $display("FAIL reset_mid_frame_writes: got %0d writes diff=%0d want 1 write %h", got_q.size(),
               first_diff(), {16'd0, 12'hABC});
    end
    total++;
    if (dut_status() !== model_status() || dbl_wen !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_frame_status: got %h dbl=%b want %h", dut_status(), dbl_wen, model_status());
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_end_marker();
    test_frame_err();
    test_overflow();
    test_glitch_stale();
    test_random_loads();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_song_loader.md
Name: uart_song_loader

Overview:
- Receives a song over the board UART_RX pin (8N1) and writes 12-bit note words into the note regfile through its write port (addr_c / data_c / wen_c).
- Sits directly upstream of the regfile; its written notes are later consumed by the music-box read stage.
- Active only while the mode controller asserts writing; a rising edge of writing starts a fresh load at address 0.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per UART bit (100 MHz / 9600 baud).
- ADDR_W, 16, regfile address width.
- DEPTH, 256, maximum note words accepted per load.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- UART_RX  input  1  asynchronous serial line; idles high.
- writing  input  1  load enable from the mode controller.
- addr_c  output  ADDR_W  regfile write address.
- data_c  output  12  regfile write data.
- wen_c  output  1  one-cycle regfile write strobe.
- busy  output  1  high while a load is open (writing=1 and no end marker seen yet).
- done  output  1  end marker received; sticky until the next load starts.
- word_cnt  output  ADDR_W  number of words written in the current load.
- frame_err  output  1  sticky: a stop bit sampled as 0.
- overflow  output  1  sticky: a word arrived when word_cnt == DEPTH.

Behaviour:
- Reset values: all outputs 0; RX FSM in IDLE; byte phase 0.
- UART_RX passes through a 2-flop synchroniser, initialised to 1 by reset.

RX FSM states: IDLE, START, DATA, STOP.
- IDLE -> START: synchronised line reads 0.
- START: count CLKS_PER_BIT/2 cycles, then resample. If 0, go to DATA and clear the bit counter. If 1 (glitch), return to IDLE with no flag.
- DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifting into rx_byte. After bit 7, go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample 1: byte_valid pulses for 1 cycle.
  - Sample 0: frame_err <= 1, byte discarded, byte phase reset to 0.
  - Either way, return to IDLE.

Word assembly (acts on byte_valid, only while busy=1):
- Phase 0, byte == 8'hFF: end marker. busy <= 0, done <= 1, no write.
- Phase 0, any other byte: hi_nib <= byte[3:0], phase <= 1. byte[7:4] is ignored.
- Phase 1:
  - data_c <= {hi_nib, byte}, addr_c <= word_cnt, wen_c <= 1 for exactly one cycle, word_cnt <= word_cnt + 1, phase <= 0.
  - Latency: wen_c is high in the cycle after the byte_valid for byte 1.
  - If word_cnt == DEPTH: no write, word_cnt holds, overflow <= 1, phase <= 0.
- Bytes received while busy=0 (writing=0, or after the end marker) are dropped; no flags change.

Load control:
- Rising edge of writing, detected against a registered copy: busy <= 1, done <= 0, word_cnt <= 0, addr_c <= 0, phase <= 0, frame_err <= 0, overflow <= 0.
- Falling edge of writing mid-word: busy <= 0, phase <= 0, partial byte discarded. word_cnt is retained so the read stage can use it as the song length.
- The RX FSM runs regardless of writing, so it stays byte-aligned when a load is enabled mid-stream.
- Simultaneous writing rise and byte_valid: the load initialisation wins and the byte is dropped.
- wen_c is never high for two consecutive cycles.
- Reset mid-frame: returns to IDLE immediately; the next start bit is received normally.

Test Plan (CLKS_PER_BIT=16, DEPTH=4 in the bench):
- Raise writing; send bytes 0x03, 0x5A -> one wen_c pulse with addr_c=0, data_c=12'h35A; word_cnt=1; busy=1.
- Send 0xF1, 0x22, then 0xFF -> write addr 1, data 12'h122 (upper nibble 0xF ignored); then done=1, busy=0, word_cnt=2; a further 0x10 byte causes no write.
- Send 0x01 with the stop bit driven 0, then 0x02, 0x34 -> frame_err=1; 0x01 discarded; write addr 0, data 12'h234.
- Send 5 two-byte words -> writes at addr 0..3 only; the 5th word gives no wen_c, overflow=1, word_cnt=4.
- Drive a 4-cycle low glitch on UART_RX in IDLE -> no byte_valid, no frame_err. Separately, send byte 0x07, drop writing, raise writing, send 0x00, 0x99 -> data_c=12'h099 at addr 0 (stale hi nibble discarded).
- Assert rst_n=0 in the middle of the DATA state -> all outputs 0; the next full frame is received correctly.
